// File: rtl/flash_word_fetcher.sv
// Fetches one DATA_W-bit word from a BUS_W-bit parallel flash as BEATS wait-stated reads,
// with a one-entry last-word cache that answers repeated addresses without touching the flash.
module flash_word_fetcher #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BUS_W       = 8,
    parameter int FL_ADDR_W   = 22,
    parameter int WAIT_CYCLES = 3,
    parameter int BASE        = 0,
    parameter int MSB_FIRST   = 0,
    parameter int CACHE_EN    = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic                 req,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 flush,
    output logic                 rdy,
    output logic [DATA_W-1:0]    data,
    output logic                 busy,
    output logic                 req_dropped,
    output logic [FL_ADDR_W-1:0] FL_ADDR,
    input  logic [BUS_W-1:0]     FL_DQ,
    output logic                 FL_CE_N,
    output logic                 FL_OE_N
);

    localparam int BEATS  = DATA_W / BUS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW_SUM = FL_ADDR_W + ADDR_W + 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [3:0]        WAIT_MAX  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HIT   = 2'd2
    } state_t;

    state_t                 r_state, w_state;
    logic [BEAT_W-1:0]      r_beat, w_beat;
    logic [3:0]             r_wcnt, w_wcnt;
    logic [ADDR_W-1:0]      r_addr, w_addr;
    logic [DATA_W-1:0]      r_word, w_word;
    logic [ADDR_W-1:0]      r_tag, w_tag;
    logic [DATA_W-1:0]      r_cache, w_cache;
    logic                   r_valid, w_valid;
    logic [DATA_W-1:0]      r_data, w_data;
    logic                   r_rdy, w_rdy;
    logic                   r_dropped, w_dropped;
    logic                   r_busy;
    logic [FL_ADDR_W-1:0]   r_fl_addr, w_fl_addr;
    logic                   r_fl_en;
    logic                   w_hit;

    // Flash byte address of a beat; wraps silently at FL_ADDR_W bits.
    function automatic logic [FL_ADDR_W-1:0] fl_addr_calc(input logic [ADDR_W-1:0] a,
                                                          input logic [BEAT_W-1:0] b);
        logic [AW_SUM-1:0] s;
        s = AW_SUM'(BASE) + AW_SUM'(a) * AW_SUM'(BEATS) + AW_SUM'(b);
        return s[FL_ADDR_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] insert_beat(input logic [DATA_W-1:0] w,
                                                      input logic [BEAT_W-1:0] b,
                                                      input logic [BUS_W-1:0]  d);
        logic [DATA_W-1:0] r;
        int                slot;
        r = w;
        if (MSB_FIRST != 0) begin
            slot = BEATS - 1 - int'(b);
        end else begin
            slot = int'(b);
        end
        r[slot*BUS_W +: BUS_W] = d;
        return r;
    endfunction

    assign w_hit = (CACHE_EN != 0) && r_valid && (addr == r_tag) && !flush;

    // Next-state, datapath and flash-pin decode.
    always_comb begin
        w_state   = r_state;
        w_beat    = r_beat;
        w_wcnt    = r_wcnt;
        w_addr    = r_addr;
        w_word    = r_word;
        w_tag     = r_tag;
        w_cache   = r_cache;
        w_valid   = r_valid & ~flush;
        w_data    = r_data;
        w_rdy     = 1'b0;
        w_dropped = r_dropped | (req & (r_state != S_IDLE));
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_addr = addr;
                    if (w_hit) begin
                        w_state = S_HIT;
                    end else begin
                        w_state = S_FETCH;
                        w_beat  = '0;
                        w_wcnt  = 4'd0;
                    end
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_HIT: begin
                w_data  = r_cache;
                w_rdy   = 1'b1;
                w_state = S_IDLE;
            end
            S_FETCH: begin
                if (r_wcnt != WAIT_MAX) begin
                    w_wcnt = r_wcnt + 4'd1;
                end else begin
                    w_wcnt = 4'd0;
                    w_word = insert_beat(r_word, r_beat, FL_DQ);
                    if (r_beat == LAST_BEAT) begin
                        // Fill is applied after the flush clear, so a simultaneous flush loses.
                        w_data  = w_word;
                        w_tag   = r_addr;
                        w_cache = w_word;
                        w_valid = 1'b1;
                        w_rdy   = 1'b1;
                        w_state = S_IDLE;
                    end else begin
                        w_beat = r_beat + BEAT_W'(1);
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
        w_fl_addr = (w_state == S_FETCH) ? fl_addr_calc(w_addr, w_beat) : '0;
    end

    // State and output registers; reset aborts any fetch and invalidates the cache.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_wcnt    <= 4'd0;
            r_addr    <= '0;
            r_word    <= '0;
            r_tag     <= '0;
            r_cache   <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_rdy     <= 1'b0;
            r_dropped <= 1'b0;
            r_busy    <= 1'b0;
            r_fl_addr <= '0;
            r_fl_en   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_beat    <= w_beat;
            r_wcnt    <= w_wcnt;
            r_addr    <= w_addr;
            r_word    <= w_word;
            r_tag     <= w_tag;
            r_cache   <= w_cache;
            r_valid   <= w_valid;
            r_data    <= w_data;
            r_rdy     <= w_rdy;
            r_dropped <= w_dropped;
            r_busy    <= (w_state != S_IDLE);
            r_fl_addr <= w_fl_addr;
            r_fl_en   <= (w_state == S_FETCH);
        end
    end

    assign rdy         = r_rdy;
    assign data        = r_data;
    assign busy        = r_busy;
    assign req_dropped = r_dropped;
    assign FL_ADDR     = r_fl_addr;
    assign FL_CE_N     = ~r_fl_en;
    assign FL_OE_N     = ~r_fl_en;

endmodule
